// File: rtl/mm_pkg.sv
// Shared constants and state encoding for the word-serial multi-precision multiplier.
// Word widths here must agree with the external 256x32 combinational multiplier.
package mm_pkg;

    localparam int WIDTH_A   = 256;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int WIDTH_B   = WORD_W * NUM_WORDS;
    localparam int WIDTH_P   = WIDTH_A + WIDTH_B;
    localparam int WIDTH_M   = WIDTH_A + WORD_W;

    // Never returns less than 1 so a single-word build still gets a legal counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int K_W = clog2(NUM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mp_shift_acc.sv
// Multi-precision accumulator: adds a partial product placed at word offset k.
// acc_sum is the post-add value, so a caller can capture the final sum on the last step.
module mp_shift_acc
    import mm_pkg::*;
#(
    parameter int ACC_W  = WIDTH_P,
    parameter int PART_W = WIDTH_M,
    parameter int STEP_W = WORD_W,
    parameter int KW     = K_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [KW-1:0]     k,
    input  logic [PART_W-1:0] part,
    output logic [ACC_W-1:0]  acc_sum
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] part_sh;

    always_comb begin
        part_sh = ACC_W'(part) << (STEP_W * k);
        acc_sum = acc + part_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/mult_256x256_seq.sv
// Word-serial 256x256 multiplier sequencer around an external 256x32 multiplier.
// One B word per cycle is presented; shifted partials accumulate into a 512-bit result.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for an operand pair, in_ready high
// ST_MUL  | stepping k through the B words, accumulating mul_p << 32k
// ST_DONE | result held on out_p/out_valid until out_ready
module mult_256x256_seq
    import mm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_A-1:0] in_a,
    input  logic [WIDTH_B-1:0] in_b,
    output logic [WIDTH_A-1:0] mul_a,
    output logic [WORD_W-1:0]  mul_b,
    input  logic [WIDTH_M-1:0] mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_P-1:0] out_p,
    output logic               busy
);

    state_t             state, state_nxt;
    logic [K_W-1:0]     k;
    logic [WIDTH_A-1:0] a_reg;
    logic [WIDTH_B-1:0] b_reg;
    logic [WIDTH_P-1:0] acc_sum;
    logic               accept;
    logic               last_word;
    logic               acc_clr;
    logic               acc_en;

    assign last_word = (k == K_W'(NUM_WORDS - 1));
    assign mul_a     = a_reg;
    assign busy      = (state == ST_MUL);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        mul_b     = '0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_MUL: begin
                acc_en = 1'b1;
                mul_b  = b_reg[k*WORD_W +: WORD_W];
                if (last_word) state_nxt = ST_DONE;
            end
            ST_DONE: in_ready = out_ready;
            default: state_nxt = ST_IDLE;
        endcase
        accept = in_valid & in_ready;
        // A result handed off in DONE can be overlapped with the next accept.
        if (accept) begin
            state_nxt = ST_MUL;
            acc_clr   = 1'b1;
        end else if (state == ST_DONE && out_ready) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            k         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_reg <= in_a;
                b_reg <= in_b;
                k     <= '0;
            end else if (acc_en) begin
                k <= last_word ? '0 : k + K_W'(1);
            end
            if (acc_en && last_word) begin
                out_p     <= acc_sum;
                out_valid <= 1'b1;
            end else if (state == ST_DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    mp_shift_acc #(
        .ACC_W  (WIDTH_P),
        .PART_W (WIDTH_M),
        .STEP_W (WORD_W),
        .KW     (K_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .en      (acc_en),
        .k       (k),
        .part    (mul_p),
        .acc_sum (acc_sum)
    );

endmodule

// File: tb/tb_mult_256x256_seq.sv
// Bench for mult_256x256_seq: provides the external multiplier, directed cases and a
// randomized stalled stream, checked against an in-order scoreboard of expected products.
module tb_mult_256x256_seq;
    import mm_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_a;
    logic [255:0] in_b;
    logic [255:0] mul_a;
    logic [31:0]  mul_b;
    logic [287:0] mul_p;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_p;
    logic         busy;

    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [511:0] exp_q[$];

    always #5 clk = ~clk;

    // The multiplier sits outside the DUT; the bench plays its role.
    assign mul_p = {32'b0, mul_a} * {256'b0, mul_b};

    mult_256x256_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    function automatic logic [511:0] ref_mul(input logic [255:0] a, input logic [255:0] b);
        return {256'b0, a} * {256'b0, b};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [511:0] e;
        check({tag, "_sb_nonempty"}, 512'(exp_q.size() != 0), 512'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, out_p, e);
        end
    endtask

    task automatic send(input logic [255:0] a, input logic [255:0] b, input logic [511:0] e);
        int w;
        w = 0;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("send_ready", 512'(in_ready), 512'd1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called just after the accepting edge; counts edges until out_valid is seen.
    task automatic collect(input string tag);
        int  edges;
        bit  seen;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            seen = out_valid;
        end
        check({tag, "_latency"}, 512'(edges), 512'(NUM_WORDS));
        pop_check(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] a, b, a2, b2, bw;
        logic [511:0] snap;
        bit           stable;
        bit           fire_in;
        int           got, cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        #12;
        check("rst_in_ready", 512'(in_ready), 512'd1);
        check("rst_out_valid", 512'(out_valid), 512'd0);
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_out_p", out_p, 512'd0);
        check("rst_mul_a", 512'(mul_a), 512'd0);
        check("rst_mul_b", 512'(mul_b), 512'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3*5 with mul_b walked word by word.
        out_ready = 1'b1;
        bw = 256'd5;
        send(256'd3, bw, 512'd15);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_mul_b", 512'(mul_b), 512'(bw[i*32 +: 32]));
            check("t1_busy", 512'(busy), 512'd1);
            check("t1_early_valid", 512'(out_valid), 512'd0);
        end
        @(negedge clk);
        check("t1_valid", 512'(out_valid), 512'd1);
        pop_check("t1_out_p");
        @(posedge clk);
        #1;
        check("t1_valid_drop", 512'(out_valid), 512'd0);
        check("t1_idle_ready", 512'(in_ready), 512'd1);
        check("t1_mul_b_idle", 512'(mul_b), 512'd0);

        // All-ones operands exercise carry through every word.
        send({256{1'b1}}, {256{1'b1}}, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1});
        collect("t2_ones");
        @(posedge clk);
        #1;

        bw = {4{32'hFFFF_FFFF, 32'h0000_0001}};
        send(256'd1, bw, {256'b0, bw});
        collect("t3_alt");
        @(posedge clk);
        #1;
        send(256'd0, bw, 512'd0);
        collect("t3_zero");
        @(posedge clk);
        #1;

        // Stall in DONE, then hand off and accept on the same edge.
        out_ready = 1'b0;
        a = rand256();
        b = rand256();
        send(a, b, ref_mul(a, b));
        collect("t4_first");
        snap   = out_p;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_p !== snap || !out_valid || in_ready) stable = 1'b0;
        end
        check("t4_stall_stable", 512'(stable), 512'd1);
        a2 = rand256();
        b2 = rand256();
        @(negedge clk);
        in_a      = a2;
        in_b      = b2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t4_overlap_ready", 512'(in_ready), 512'd1);
        exp_q.push_back(ref_mul(a2, b2));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t4_valid_drop", 512'(out_valid), 512'd0);
        check("t4_busy", 512'(busy), 512'd1);
        collect("t4_second");
        @(posedge clk);
        #1;

        // Reset in the middle of MUL at k=4.
        a = rand256();
        b = rand256();
        send(a, b, ref_mul(a, b));
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 512'(out_valid), 512'd0);
        check("t5_rst_busy", 512'(busy), 512'd0);
        check("t5_rst_ready", 512'(in_ready), 512'd1);
        check("t5_rst_out_p", out_p, 512'd0);
        check("t5_rst_mul_a", 512'(mul_a), 512'd0);
        check("t5_rst_mul_b", 512'(mul_b), 512'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(256'd7, 256'd9, 512'd63);
        collect("t5_after_rst");
        @(posedge clk);
        #1;

        // Random stream with random input gaps and output stalls.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        got       = 0;
        cyc       = 0;
        fire_in   = 1'b0;
        begin
            int sent;
            sent = 0;
            while (got < 1000 && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                    in_a     = rand256();
                    in_b     = rand256();
                    in_valid = 1'b1;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                fire_in = in_valid & in_ready;
                if (out_valid && out_ready) begin
                    pop_check("rand");
                    got++;
                end
                if (fire_in) begin
                    exp_q.push_back(ref_mul(in_a, in_b));
                    sent++;
                end
                @(posedge clk);
                #1;
                if (fire_in) in_valid = 1'b0;
            end
        end
        check("rand_count", 512'(got), 512'd1000);
        check("rand_sb_drained", 512'(exp_q.size()), 512'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
